// File: rtl/risc_sequencer_if.sv
// Control bundle between the VeriRisc sequencer and the datapath: opcode/zero in,
// per-phase strobes and the debug phase out.
interface risc_sequencer_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       halt;
    logic       inc_pc;
    logic       ld_ac;
    logic       ld_pc;
    logic       wr;
    logic       data_e;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase
    );
endinterface

// File: rtl/risc_sequencer.sv
// VeriRisc 8-phase instruction sequencer: free-running phase counter plus a sticky
// halted flag, with all control strobes decoded combinationally from that state.
module risc_sequencer (
    input logic              clk,
    input logic              rst,
    risc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StInstAddr  = 3'd0,
        StInstFetch = 3'd1,
        StInstLoad  = 3'd2,
        StIdle      = 3'd3,
        StOpAddr    = 3'd4,
        StOpFetch   = 3'd5,
        StAluOp     = 3'd6,
        StStore     = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OpHlt = 3'd0,
        OpSkz = 3'd1,
        OpAdd = 3'd2,
        OpAnd = 3'd3,
        OpXor = 3'd4,
        OpLda = 3'd5,
        OpSto = 3'd6,
        OpJmp = 3'd7
    } opcode_e;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    logic is_hlt, is_skz, is_sto, is_jmp, aluop;

    assign is_hlt = (bus.opcode == OpHlt);
    assign is_skz = (bus.opcode == OpSkz);
    assign is_sto = (bus.opcode == OpSto);
    assign is_jmp = (bus.opcode == OpJmp);
    assign aluop  = (bus.opcode == OpAdd) || (bus.opcode == OpAnd) ||
                    (bus.opcode == OpXor) || (bus.opcode == OpLda);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= StInstAddr;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Halt entry freezes the phase at OP_ADDR instead of advancing.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == StOpAddr && is_hlt) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.halt   = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        if (halted_q) begin
            bus.halt = 1'b1;
        end else begin
            unique case (phase_q)
                StInstAddr: begin
                    bus.sel = 1'b1;
                end
                StInstFetch: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                StInstLoad, StIdle: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                StOpAddr: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = is_hlt;
                end
                StOpFetch: begin
                    bus.rd = aluop;
                end
                StAluOp: begin
                    bus.rd     = aluop;
                    bus.inc_pc = is_skz && bus.zero;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                end
                // JMP raises both ld_pc and inc_pc here; the counter's load wins.
                StStore: begin
                    bus.rd     = aluop;
                    bus.ld_ac  = aluop;
                    bus.inc_pc = is_jmp;
                    bus.ld_pc  = is_jmp;
                    bus.wr     = is_sto;
                    bus.data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase = phase_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Self-checking bench for risc_sequencer: vector table, directed corner sequences,
// and randomized cycles against a phase/mask reference model.
module tb_risc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    risc_sequencer_if bus ();

    risc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_phase  = 0;
    bit m_halted = 1'b0;

    // Program counter model fed by the strobes
    logic [4:0] cnt;
    logic [4:0] cnt_in = 5'h0A;
    always @(posedge clk) begin
        if (rst)             cnt <= 5'h00;
        else if (bus.ld_pc)  cnt <= cnt_in;
        else if (bus.inc_pc) cnt <= cnt + 5'd1;
    end

    // Output vector: {phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
    function automatic logic [11:0] observed();
        return {bus.phase, bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
                bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};
    endfunction

    // Each strobe is an 8-bit mask over phases, bit n = asserted in phase n.
    function automatic logic [11:0] model_out(int ph, bit halted, logic [2:0] op, logic z);
        bit aluop;
        logic [7:0] sel_m, rd_m, ir_m, halt_m, inc_m, ac_m, pc_m, wr_m, de_m;
        if (halted) return {3'(ph), 9'b000100000};
        aluop  = (op >= 3'd2 && op <= 3'd5);
        sel_m  = 8'h0F;
        rd_m   = 8'h0E | (aluop ? 8'hE0 : 8'h00);
        ir_m   = 8'h0C;
        halt_m = (op == 3'd0) ? 8'h10 : 8'h00;
        inc_m  = 8'h10 | ((op == 3'd1 && z) ? 8'h40 : 8'h00) | ((op == 3'd7) ? 8'h80 : 8'h00);
        ac_m   = aluop ? 8'h80 : 8'h00;
        pc_m   = (op == 3'd7) ? 8'hC0 : 8'h00;
        wr_m   = (op == 3'd6) ? 8'h80 : 8'h00;
        de_m   = (op == 3'd6) ? 8'hC0 : 8'h00;
        return {3'(ph), sel_m[ph], rd_m[ph], ir_m[ph], halt_m[ph], inc_m[ph],
                ac_m[ph], pc_m[ph], wr_m[ph], de_m[ph]};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive inputs, take one edge, advance the model, settle.
    task automatic step(input logic r, input logic [2:0] op, input logic z);
        rst        = r;
        bus.opcode = op;
        bus.zero   = z;
        @(posedge clk);
        if (r) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
            else                            m_phase  = (m_phase + 1) % 8;
        end
        #1;
    endtask

    task automatic run_checked(input string name, input logic [2:0] op, input logic z,
                               input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, op, z);
            check(name, observed(), model_out(m_phase, m_halted, op, z));
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic [2:0] opcode;
        logic       zero;
        logic [2:0] exp_phase;
        logic [8:0] exp_out;
    } vec_t;

    vec_t vecs[17];
    logic ac_seen;
    logic [2:0] rop;
    logic rz, rr;

    initial begin
        // Reset then LDA, then STO, one vector per clock edge
        vecs[0]  = '{1'b1, 3'd5, 1'b0, 3'd0, 9'b100000000};
        vecs[1]  = '{1'b0, 3'd5, 1'b0, 3'd1, 9'b110000000};
        vecs[2]  = '{1'b0, 3'd5, 1'b0, 3'd2, 9'b111000000};
        vecs[3]  = '{1'b0, 3'd5, 1'b0, 3'd3, 9'b111000000};
        vecs[4]  = '{1'b0, 3'd5, 1'b0, 3'd4, 9'b000010000};
        vecs[5]  = '{1'b0, 3'd5, 1'b0, 3'd5, 9'b010000000};
        vecs[6]  = '{1'b0, 3'd5, 1'b0, 3'd6, 9'b010000000};
        vecs[7]  = '{1'b0, 3'd5, 1'b0, 3'd7, 9'b010001000};
        vecs[8]  = '{1'b0, 3'd6, 1'b0, 3'd0, 9'b100000000};
        vecs[9]  = '{1'b0, 3'd6, 1'b0, 3'd1, 9'b110000000};
        vecs[10] = '{1'b0, 3'd6, 1'b0, 3'd2, 9'b111000000};
        vecs[11] = '{1'b0, 3'd6, 1'b0, 3'd3, 9'b111000000};
        vecs[12] = '{1'b0, 3'd6, 1'b0, 3'd4, 9'b000010000};
        vecs[13] = '{1'b0, 3'd6, 1'b0, 3'd5, 9'b000000000};
        vecs[14] = '{1'b0, 3'd6, 1'b0, 3'd6, 9'b000000001};
        vecs[15] = '{1'b0, 3'd6, 1'b0, 3'd7, 9'b000000011};
        vecs[16] = '{1'b0, 3'd6, 1'b0, 3'd0, 9'b100000000};

        bus.opcode = 3'd0;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].opcode, vecs[i].zero);
            check($sformatf("vec%0d", i), observed(), {vecs[i].exp_phase, vecs[i].exp_out});
        end

        // SKZ taken: two increments per instruction
        step(1'b1, 3'd1, 1'b1);
        run_checked("skz_z1", 3'd1, 1'b1, 8);
        check("skz_z1_cnt", {7'd0, cnt}, 12'd2);
        // SKZ not taken: one increment
        run_checked("skz_z0", 3'd1, 1'b0, 8);
        check("skz_z0_cnt", {7'd0, cnt}, 12'd3);

        // JMP loads cnt_in by the next phase 0
        step(1'b1, 3'd7, 1'b0);
        run_checked("jmp", 3'd7, 1'b0, 8);
        check("jmp_cnt", {7'd0, cnt}, 12'h00A);

        // HLT: freeze at phase 4 regardless of later opcodes
        step(1'b1, 3'd0, 1'b0);
        run_checked("hlt_enter", 3'd0, 1'b0, 4);
        check("hlt_phase4", observed(), {3'd4, 9'b000110000});
        step(1'b0, 3'd0, 1'b0);
        check("hlt_frozen", observed(), {3'd4, 9'b000100000});
        run_checked("hlt_hold", 3'd2, 1'b1, 12);
        check("hlt_hold_end", observed(), {3'd4, 9'b000100000});
        step(1'b1, 3'd2, 1'b0);
        check("hlt_reset", observed(), {3'd0, 9'b100000000});

        // Reset during ALU_OP of an ADD: ld_ac must never pulse
        step(1'b1, 3'd2, 1'b0);
        ac_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'd2, 1'b0);
            ac_seen = ac_seen | bus.ld_ac;
        end
        check("mid_at6", {9'd0, bus.phase}, 12'd6);
        step(1'b1, 3'd2, 1'b0);
        ac_seen = ac_seen | bus.ld_ac;
        check("mid_reset", observed(), {3'd0, 9'b100000000});
        check("mid_no_ldac", {11'd0, ac_seen}, 12'd0);
        run_checked("mid_resume", 3'd2, 1'b0, 9);

        // Randomized: opcode changes only at phase 0, occasional reset
        rop = 3'($urandom_range(1, 7));
        for (int i = 0; i < 2000; i++) begin
            if (m_phase == 0 || m_halted) rop = 3'($urandom_range(0, 7));
            rz = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 39) == 0);
            step(rr, rop, rz);
            check("rand", observed(), model_out(m_phase, m_halted, rop, rz));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- Central 8-phase instruction sequencer of the VeriRisc CPU.
- Sits directly upstream of the program counter. Its inc_pc output drives the counter's enab. Its ld_pc output drives the counter's load.
- Also issues the memory, instruction-register, accumulator and data-bus strobes for every instruction.
- Holds a free-running 3-bit phase counter plus a sticky halted flag. All control outputs decode combinationally from registered state and the current opcode and zero flag.

Parameters:
none (opcode field fixed at 3 bits; encodings fixed below)

Ports:
clk      input   1  system clock; all state updates on rising edge
rst      input   1  synchronous, active-high reset
opcode   input   3  instruction opcode from the instruction register
zero     input   1  accumulator-is-zero flag
sel      output  1  address mux select: 1 = PC, 0 = IR operand
rd       output  1  memory read strobe
ld_ir    output  1  instruction register load
halt     output  1  processor halted / halting
inc_pc   output  1  PC increment; connects to counter enab
ld_ac    output  1  accumulator load
ld_pc    output  1  PC load; connects to counter load
wr       output  1  memory write strobe
data_e   output  1  data bus drive enable
phase    output  3  current phase, for debug and bench visibility

Behaviour:
- Opcode encodings: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = (opcode is ADD, AND, XOR or LDA).
- State: phase[2:0] and halted.
- Reset, at the clock edge with rst=1: phase<=0, halted<=0. Reset has priority over everything, including the halted state and any mid-instruction phase.
- Normal advance: phase<=phase+1 each clock. Wraps 7->0 with no idle cycle.
- Halt entry: if phase==4 and opcode==HLT and !halted, set halted<=1 and leave phase at 4.
- Halted state: phase frozen; halted sticky until rst.
- Outputs when halted=1: halt=1, all other control outputs 0, phase output holds 4.
- Outputs when halted=0, decoded per phase. Any output not listed is 0.
  - phase 0 INST_ADDR: sel=1.
  - phase 1 INST_FETCH: sel=1, rd=1.
  - phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - phase 3 IDLE: sel=1, rd=1, ld_ir=1.
  - phase 4 OP_ADDR: inc_pc=1; halt=(opcode==HLT).
  - phase 5 OP_FETCH: rd=ALUOP.
  - phase 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - phase 7 STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=(opcode==JMP); ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- In phase 7 for JMP, ld_pc and inc_pc are both 1. The counter's load priority resolves this.
- Output values right after the reset edge: sel=1, all others 0, phase=0.
- Latency:
  - Outputs are valid in the same cycle the phase is entered.
  - opcode and zero are used combinationally, with no registering.
  - opcode must be stable from phase 4 through phase 7. It is set by the IR load in phase 2/3.
- An instruction takes exactly 8 cycles. PC increments once per instruction in phase 4. SKZ with zero=1 gives a second increment in phase 6.
- X/unknown opcode is not required to be handled. Outputs in that case are don't-care.

Test Plan:
- Reset then LDA: rst=1 for 1 edge, then opcode=5, zero=0, for 8 clocks.
  - Phase steps 0..7 then returns to 0.
  - sel=1 in phases 0-3; rd=1 in phases 1-3 and 5-7; ld_ir=1 in phases 2-3; inc_pc=1 only in phase 4; ld_ac=1 only in phase 7; wr=0 and ld_pc=0 throughout.
- STO: opcode=6.
  - data_e=1 in phases 6-7; wr=1 only in phase 7; rd=0 and ld_ac=0 in phases 5-7.
- SKZ: opcode=1.
  - zero=1: inc_pc=1 in phases 4 and 6 (two counter increments).
  - zero=0: inc_pc=1 only in phase 4.
- JMP: opcode=7.
  - ld_pc=1 in phases 6 and 7; inc_pc=1 in phases 4 and 7.
  - With the counter attached and cnt_in=5'h0A, cnt_out=5'h0A at the phase-0 negedge of the next instruction.
- HLT: opcode=0.
  - halt=1 and inc_pc=1 in phase 4.
  - Afterwards: phase stays 4 for 10+ clocks, halt=1, every other output 0, even if opcode changes to 2.
  - rst=1 for one edge: phase=0, halt=0, sel=1.
- Reset mid-instruction: assert rst during phase 6 of an ADD (opcode=2).
  - Next edge: phase=0, ld_ac never pulses.
  - Normal sequencing resumes on the following cycles.
